// File: rtl/regfile_sb.sv
// Two-write, two-read register file with optional write-to-read bypass,
// hardwired zero register and a per-register pending scoreboard.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              c,
  input  logic              r,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy1,
  output logic              busy2,
  input  logic              wea,
  input  logic [ADDR_W-1:0] waa,
  input  logic [DATA_W-1:0] wda,
  input  logic              web,
  input  logic [ADDR_W-1:0] wab,
  input  logic [DATA_W-1:0] wdb,
  input  logic              iss,
  input  logic [ADDR_W-1:0] isa,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pending_nxt;
  logic              wa_ok;
  logic              wb_ok;
  logic              is_ok;
  logic              conflict;
  logic              reissue;
  logic              inc;
  logic              dec_a;
  logic              dec_b;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // Qualified write/issue strobes and scoreboard next state
  always_comb begin
    wa_ok       = wea && !r && !is_zero(waa);
    wb_ok       = web && !r && !is_zero(wab);
    is_ok       = iss && !r && !is_zero(isa);
    conflict    = wa_ok && wb_ok && (waa == wab);
    reissue     = is_ok && pending[isa];
    inc         = is_ok && !pending[isa];
    // A write landing on the issued address is overridden by the issue
    dec_a       = wa_ok && pending[waa] && !(is_ok && (isa == waa));
    dec_b       = wb_ok && pending[wab] && !(is_ok && (isa == wab))
                  && !(wa_ok && (waa == wab));
    pending_nxt = pending;
    if (wa_ok) pending_nxt[waa] = 1'b0;
    if (wb_ok) pending_nxt[wab] = 1'b0;
    if (is_ok) pending_nxt[isa] = 1'b1;
  end

  // Register array; port B is applied last so it wins an address clash
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wa_ok) regs[waa] <= wda;
      if (wb_ok) regs[wab] <= wdb;
    end
  end

  // Scoreboard, pending count and sticky error
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      pending  <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec_a) - CNT_W'(dec_b);
      if (conflict || reissue) err <= 1'b1;
    end
  end

  // Combinational read ports
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (!r) begin
      rd1   = regs[ra1];
      rd2   = regs[ra2];
      busy1 = pending[ra1];
      busy2 = pending[ra2];
      if (BYPASS) begin
        if (wa_ok && (waa == ra1)) rd1 = wda;
        if (wb_ok && (wab == ra1)) rd1 = wdb;
        if (wa_ok && (waa == ra2)) rd2 = wda;
        if (wb_ok && (wab == ra2)) rd2 = wdb;
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypass and a non-bypass instance share stimulus and
// are compared against vector tables, directed sequences and a reference model.
module tb_regfile_sb;

  logic        c = 1'b0;
  logic        r;
  logic [4:0]  ra1, ra2, waa, wab, isa;
  logic [31:0] wda, wdb;
  logic        wea, web, iss;

  logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
  logic        busy1_b, busy2_b, busy1_n, busy2_n, err_b, err_n;
  logic [5:0]  cnt_b, cnt_n;

  int tests = 0;
  int failed = 0;

  regfile_sb u_byp (
    .c(c), .r(r), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .busy1(busy1_b), .busy2(busy2_b), .wea(wea), .waa(waa), .wda(wda),
    .web(web), .wab(wab), .wdb(wdb), .iss(iss), .isa(isa),
    .pend_cnt(cnt_b), .err(err_b)
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .c(c), .r(r), .ra1(ra1), .ra2(ra2), .rd1(rd1_n), .rd2(rd2_n),
    .busy1(busy1_n), .busy2(busy2_n), .wea(wea), .waa(waa), .wda(wda),
    .web(web), .wab(wab), .wdb(wdb), .iss(iss), .isa(isa),
    .pend_cnt(cnt_n), .err(err_n)
  );

  always #5 c = ~c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference model: architectural state only
  logic [31:0] m_mem [32];
  bit          m_pend [32];
  bit          m_err;

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  // Apply one clock edge's worth of effects from the current inputs
  task automatic model_edge();
    bit a_ok, b_ok, i_ok;
    a_ok = wea && (waa != 0);
    b_ok = web && (wab != 0);
    i_ok = iss && (isa != 0);
    if (a_ok && b_ok && waa == wab) m_err = 1'b1;
    if (i_ok && m_pend[isa]) m_err = 1'b1;
    if (a_ok) begin m_mem[waa] = wda; m_pend[waa] = 1'b0; end
    if (b_ok) begin m_mem[wab] = wdb; m_pend[wab] = 1'b0; end
    if (i_ok) m_pend[isa] = 1'b1;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra, input bit byp);
    if (ra == 0) return '0;
    if (byp) begin
      if (web && wab != 0 && wab == ra) return wdb;
      if (wea && waa != 0 && waa == ra) return wda;
    end
    return m_mem[ra];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("rd1_byp", 64'(rd1_b), 64'(exp_rd(ra1, 1'b1)));
    chk("rd2_byp", 64'(rd2_b), 64'(exp_rd(ra2, 1'b1)));
    chk("rd1_nb", 64'(rd1_n), 64'(exp_rd(ra1, 1'b0)));
    chk("rd2_nb", 64'(rd2_n), 64'(exp_rd(ra2, 1'b0)));
    chk("busy1", 64'(busy1_b), 64'(m_pend[ra1]));
    chk("busy2", 64'(busy2_b), 64'(m_pend[ra2]));
    chk("busy1_nb", 64'(busy1_n), 64'(m_pend[ra1]));
    chk("pend_cnt", 64'(cnt_b), 64'(m_cnt()));
    chk("pend_cnt_nb", 64'(cnt_n), 64'(m_cnt()));
    chk("err", 64'(err_b), 64'(m_err));
    chk("err_nb", 64'(err_n), 64'(m_err));
  endtask

  task automatic idle();
    wea = 0; waa = 0; wda = 0;
    web = 0; wab = 0; wdb = 0;
    iss = 0; isa = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge c);
    #1;
  endtask

  task automatic do_reset();
    idle();
    r = 1'b1;
    model_reset();
    @(posedge c);
    #1;
    r = 1'b0;
  endtask

  typedef struct {
    logic        wea;
    logic [4:0]  waa;
    logic [31:0] wda;
    logic        web;
    logic [4:0]  wab;
    logic [31:0] wdb;
    logic        iss;
    logic [4:0]  isa;
    logic [4:0]  ra1;
    logic [31:0] e_rd_b;
    logic [31:0] e_rd_n;
    logic        e_busy;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  vec_t vt [10];

  initial begin
    idle();
    ra1 = 0; ra2 = 0;
    r = 1'b1;
    model_reset();
    repeat (2) @(posedge c);
    #1;
    r = 1'b0;

    // Reset state on every address, and register 0 ignoring writes
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      chk("rst_rd1", 64'(rd1_b), 64'd0);
      chk("rst_rd2", 64'(rd2_n), 64'd0);
      chk("rst_busy1", 64'(busy1_b), 64'd0);
      chk("rst_busy2", 64'(busy2_n), 64'd0);
    end
    chk("rst_cnt", 64'(cnt_b), 64'd0);
    chk("rst_err", 64'(err_b), 64'd0);
    @(posedge c); #1;
    wea = 1; waa = 0; wda = 32'hDEADBEEF; ra1 = 0;
    #1;
    chk("zero_byp", 64'(rd1_b), 64'd0);
    tick();
    idle();
    #1;
    chk("zero_after_b", 64'(rd1_b), 64'd0);
    chk("zero_after_n", 64'(rd1_n), 64'd0);
    chk("zero_err", 64'(err_b), 64'd0);

    // Vector table: write, bypass, scoreboard and conflict cases
    vt[0] = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h12345678, 32'h0,        1'b0, 6'd0, 1'b0};
    vt[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 6'd0, 1'b0};
    vt[2] = '{1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 6'd0, 1'b0};
    vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'h0,        32'h0,        1'b1, 6'd1, 1'b0};
    vt[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 5'd3, 32'hAA,      32'h0,        1'b0, 6'd0, 1'b0};
    vt[5] = '{1'b1, 5'd3, 32'hBB,       1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'hBB,       32'hAA,       1'b1, 6'd1, 1'b0};
    vt[6] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd3, 32'hBB,       32'hBB,       1'b1, 6'd2, 1'b0};
    vt[7] = '{1'b1, 5'd3, 32'h1,        1'b1, 5'd4, 32'h2, 1'b0, 5'd0, 5'd4, 32'h2,        32'h0,        1'b0, 6'd0, 1'b0};
    vt[8] = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 5'd7, 32'h2,        32'h0,        1'b0, 6'd0, 1'b1};
    vt[9] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h2,        32'h2,        1'b0, 6'd0, 1'b1};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      wea = vt[i].wea; waa = vt[i].waa; wda = vt[i].wda;
      web = vt[i].web; wab = vt[i].wab; wdb = vt[i].wdb;
      iss = vt[i].iss; isa = vt[i].isa; ra1 = vt[i].ra1; ra2 = 0;
      #1;
      chk($sformatf("vec%0d_rd_byp", i), 64'(rd1_b), 64'(vt[i].e_rd_b));
      chk($sformatf("vec%0d_rd_nb", i), 64'(rd1_n), 64'(vt[i].e_rd_n));
      tick();
      idle();
      #1;
      chk($sformatf("vec%0d_busy", i), 64'(busy1_b), 64'(vt[i].e_busy));
      chk($sformatf("vec%0d_cnt", i), 64'(cnt_b), 64'(vt[i].e_cnt));
      chk($sformatf("vec%0d_err", i), 64'(err_b), 64'(vt[i].e_err));
    end

    // Fill every issuable register, re-issue, then drain two per edge
    do_reset();
    for (int a = 1; a < 32; a++) begin
      iss = 1; isa = 5'(a);
      tick();
    end
    idle();
    #1;
    chk("fill_cnt", 64'(cnt_b), 64'd31);
    chk("fill_err", 64'(err_b), 64'd0);
    iss = 1; isa = 5'd4; ra1 = 5'd4;
    tick();
    idle();
    #1;
    chk("reissue_err", 64'(err_b), 64'd1);
    chk("reissue_cnt", 64'(cnt_b), 64'd31);
    chk("reissue_busy", 64'(busy1_b), 64'd1);
    for (int k = 0; k < 15; k++) begin
      wea = 1; waa = 5'(2 * k + 1); wda = 32'(k + 1);
      web = 1; wab = 5'(2 * k + 2); wdb = 32'(k + 100);
      tick();
      idle();
      #1;
      chk($sformatf("drain%0d_cnt", k), 64'(cnt_b), 64'(31 - 2 * (k + 1)));
    end
    wea = 1; waa = 5'd31; wda = 32'h31;
    tick();
    idle();
    #1;
    chk("drain_last_cnt", 64'(cnt_b), 64'd0);
    chk("drain_err_sticky", 64'(err_b), 64'd1);
    check_all();

    // Asynchronous reset between edges with live state
    do_reset();
    for (int a = 11; a <= 20; a++) begin
      wea = 1; waa = 5'(a); wda = 32'hA000 + 32'(a);
      tick();
    end
    for (int a = 1; a <= 10; a++) begin
      iss = 1; isa = 5'(a);
      idle(); iss = 1; isa = 5'(a);
      tick();
    end
    idle();
    wea = 1; web = 1; waa = 5'd25; wab = 5'd25; wda = 32'h1; wdb = 32'h2;
    tick();
    idle();
    ra1 = 5'd11; ra2 = 5'd1;
    #1;
    chk("pre_rst_cnt", 64'(cnt_b), 64'd10);
    chk("pre_rst_rd1", 64'(rd1_n), 64'hA00B);
    chk("pre_rst_err", 64'(err_b), 64'd1);
    #1;
    r = 1'b1;
    #1;
    chk("async_rd1_b", 64'(rd1_b), 64'd0);
    chk("async_rd1_n", 64'(rd1_n), 64'd0);
    chk("async_busy2", 64'(busy2_b), 64'd0);
    chk("async_cnt", 64'(cnt_b), 64'd0);
    chk("async_err", 64'(err_b), 64'd0);
    model_reset();
    @(posedge c);
    #1;
    r = 1'b0;
    wea = 1; waa = 5'd9; wda = 32'h99; ra1 = 5'd9;
    #1;
    chk("post_rst_byp", 64'(rd1_b), 64'h99);
    chk("post_rst_nb_old", 64'(rd1_n), 64'd0);
    tick();
    idle();
    #1;
    chk("post_rst_nb_new", 64'(rd1_n), 64'h99);
    chk("post_rst_cnt", 64'(cnt_b), 64'd0);
    ra1 = 5'd11;
    #1;
    chk("post_rst_cleared", 64'(rd1_b), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wea = ($urandom_range(0, 2) == 0);
      web = ($urandom_range(0, 2) == 0);
      iss = ($urandom_range(0, 1) == 0);
      waa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wab = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      isa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra1 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ra2 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wda = $urandom;
      wdb = $urandom;
      #1;
      check_all();
      tick();
    end
    idle();
    #1;
    check_all();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
